// File: rtl/softmax_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : softmax_seq_if
// Brief    : Handshake/operand bundle between softmax_seq and its shared units.
// Revision : 1.0
// ============================================================================
interface softmax_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  exp_enable;
    logic [DATA_WIDTH-1:0] exp_x;
    logic [DATA_WIDTH-1:0] exp_result;
    logic                  exp_ack;
    logic                  rec_enable;
    logic [DATA_WIDTH-1:0] rec_number;
    logic [DATA_WIDTH-1:0] rec_out;
    logic                  rec_ack;
    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] add_sum;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [DATA_WIDTH-1:0] mul_p;

    modport master (
        output exp_enable, exp_x, rec_enable, rec_number, add_a, add_b, mul_a, mul_b,
        input  exp_result, exp_ack, rec_out, rec_ack, add_sum, mul_p
    );

    modport slave (
        input  exp_enable, exp_x, rec_enable, rec_number, add_a, add_b, mul_a, mul_b,
        output exp_result, exp_ack, rec_out, rec_ack, add_sum, mul_p
    );
endinterface
`default_nettype wire

// File: rtl/softmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : softmax_seq
// Brief    : Time-multiplexed softmax sequencer sharing one exp, reciprocal,
//            adder and multiplier unit across INPUT_NUM class scores.
//            Optional request watchdog: define SOFTMAX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module softmax_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUT_NUM  = 10
`ifdef SOFTMAX_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [DATA_WIDTH*INPUT_NUM-1:0] inputs,
    output logic [DATA_WIDTH*INPUT_NUM-1:0] outputs,
    output logic                            ackSoft,
    output logic                            error,
    softmax_seq_if.master                   bus
);

    localparam int IW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(INPUT_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXP_REQ = 3'd1,
        S_EXP_GAP = 3'd2,
        S_REC_REQ = 3'd3,
        S_MUL     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_recip;
    logic                  r_ack;
    logic                  r_exp_en;
    logic                  r_rec_en;
    logic [DATA_WIDTH-1:0] r_operand [INPUT_NUM];
    logic [DATA_WIDTH-1:0] r_exp_buf [INPUT_NUM];
    logic [DATA_WIDTH-1:0] r_out     [INPUT_NUM];

`ifdef SOFTMAX_TIMEOUT_EN
    localparam int c_TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_tmo;
    logic            r_error;
    logic            w_tmo_hit;

    assign w_tmo_hit = (r_tmo == c_TMO_LAST);
    assign error     = r_error;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_sum    <= '0;
            r_recip  <= '0;
            r_ack    <= 1'b0;
            r_exp_en <= 1'b0;
            r_rec_en <= 1'b0;
            for (int i = 0; i < INPUT_NUM; i++) begin
                r_operand[i] <= '0;
                r_exp_buf[i] <= '0;
                r_out[i]     <= '0;
            end
`ifdef SOFTMAX_TIMEOUT_EN
            r_tmo   <= '0;
            r_error <= 1'b0;
`endif
        end else if (r_state != S_IDLE && !enable) begin
            // Abort (and the normal DONE exit): already-written outputs are kept
            r_state  <= S_IDLE;
            r_exp_en <= 1'b0;
            r_rec_en <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (enable) begin
                        for (int i = 0; i < INPUT_NUM; i++) begin
                            r_operand[i] <= inputs[DATA_WIDTH*i +: DATA_WIDTH];
                        end
                        r_idx    <= '0;
                        r_sum    <= '0;
                        r_exp_en <= 1'b1;
                        r_state  <= S_EXP_REQ;
`ifdef SOFTMAX_TIMEOUT_EN
                        r_tmo   <= '0;
                        r_error <= 1'b0;
`endif
                    end
                end
                S_EXP_REQ: begin
                    if (bus.exp_ack) begin
                        r_exp_buf[r_idx] <= bus.exp_result;
                        r_sum            <= bus.add_sum;
                        r_exp_en         <= 1'b0;
                        r_state          <= S_EXP_GAP;
                    end
`ifdef SOFTMAX_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_exp_en <= 1'b0;
                        r_error  <= 1'b1;
                        r_ack    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
`endif
                end
                S_EXP_GAP: begin
                    // One idle cycle lets the exp unit see a fresh rising request
`ifdef SOFTMAX_TIMEOUT_EN
                    r_tmo <= '0;
`endif
                    if (r_idx == c_LAST_IDX) begin
                        r_rec_en <= 1'b1;
                        r_state  <= S_REC_REQ;
                    end else begin
                        r_idx    <= r_idx + IW'(1);
                        r_exp_en <= 1'b1;
                        r_state  <= S_EXP_REQ;
                    end
                end
                S_REC_REQ: begin
                    if (bus.rec_ack) begin
                        r_recip  <= bus.rec_out;
                        r_idx    <= '0;
                        r_rec_en <= 1'b0;
                        r_state  <= S_MUL;
                    end
`ifdef SOFTMAX_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_rec_en <= 1'b0;
                        r_error  <= 1'b1;
                        r_ack    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
`endif
                end
                S_MUL: begin
                    r_out[r_idx] <= bus.mul_p;
                    if (r_idx == c_LAST_IDX) begin
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_ack <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.exp_enable = r_exp_en;
    assign bus.exp_x      = r_operand[r_idx];
    assign bus.rec_enable = r_rec_en;
    assign bus.rec_number = r_sum;
    assign bus.add_a      = bus.exp_result;
    assign bus.add_b      = r_sum;
    assign bus.mul_a      = r_exp_buf[r_idx];
    assign bus.mul_b      = r_recip;
    assign ackSoft        = r_ack;

    generate
        for (genvar g = 0; g < INPUT_NUM; g++) begin : g_pack
            assign outputs[DATA_WIDTH*g +: DATA_WIDTH] = r_out[g];
        end
    endgenerate

endmodule
`default_nettype wire
